// File: rtl/irq_prio_ctrl.sv
// Priority interrupt controller: synchronised sources, edge/level pending, priority arbitration, claim/complete.
// Latency: source change to irq_out in SYNC_STAGES+2 edges; register port is single-cycle with no backpressure.
module irq_prio_ctrl #(
    parameter int NUM_IRQS    = 32,
    parameter int PRIO_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQS-1:0]   irq_in,
    output logic                  irq_out,
    output logic [4:0]            irq_id,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [DATA_WIDTH-1:0] reg_rdata
);
    localparam int IDW = 5;

    logic [NUM_IRQS-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_IRQS-1:0]   act_d_q, pending_q, pending_d, enable_q, type_q, pol_q;
    logic [NUM_IRQS-1:0]   insvc_q, insvc_d;
    logic [PRIO_WIDTH-1:0] prio_q [NUM_IRQS];
    logic [PRIO_WIDTH-1:0] thr_q, best_p;
    logic                  sup_q, win_vld_q, win_vld_d;
    logic [IDW-1:0]        win_id_q, win_id_d;

    logic [NUM_IRQS-1:0] act, edge_rise, edge_clr, w1c, claim_mask, cmpl_mask, elig, hit_prio;
    logic [NUM_IRQS-1:0] wdat_n;
    logic wr_en, rd_en, claim_fire;
    logic hit_status, hit_enable, hit_type, hit_pol, hit_thr, hit_raw, hit_claim, hit_insvc;
    logic unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign wdat_n       = reg_wdata[NUM_IRQS-1:0];
    assign wr_en        = reg_wr;
    assign rd_en        = reg_rd & ~reg_wr;

    assign hit_status = (reg_addr == ADDR_WIDTH'('h00));
    assign hit_enable = (reg_addr == ADDR_WIDTH'('h04));
    assign hit_type   = (reg_addr == ADDR_WIDTH'('h08));
    assign hit_pol    = (reg_addr == ADDR_WIDTH'('h0C));
    assign hit_thr    = (reg_addr == ADDR_WIDTH'('h10));
    assign hit_raw    = (reg_addr == ADDR_WIDTH'('h14));
    assign hit_claim  = (reg_addr == ADDR_WIDTH'('h18));
    assign hit_insvc  = (reg_addr == ADDR_WIDTH'('h1C));

    assign act        = sync_q[SYNC_STAGES-1] ^ pol_q;
    assign edge_rise  = act & ~act_d_q & {NUM_IRQS{~sup_q}};
    assign w1c        = (wr_en && hit_status) ? wdat_n : '0;
    assign claim_fire = rd_en & hit_claim & win_vld_q;

    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        hit_prio   = '0;
        elig       = '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            hit_prio[i]   = (reg_addr == ADDR_WIDTH'(64 + 4 * i));
            claim_mask[i] = claim_fire && (win_id_q == IDW'(i));
            // Ids at or beyond NUM_IRQS never match any bit, so they are ignored.
            cmpl_mask[i]  = wr_en && hit_claim && (reg_wdata[IDW-1:0] == IDW'(i)) && insvc_q[i];
            elig[i]       = (prio_q[i] > thr_q);
        end
        // The source claimed this cycle is already excluded, so irq_out drops on the claim edge.
        elig      = elig & pending_q & enable_q & ~(insvc_q | claim_mask);
        edge_clr  = w1c | (claim_mask & type_q);
        pending_d = (type_q & ((pending_q & ~edge_clr) | edge_rise)) | (~type_q & act);
        insvc_d   = (insvc_q & ~cmpl_mask) | claim_mask;
    end

    // Strict compare while scanning upward keeps the lowest id on equal priority.
    always_comb begin
        best_p    = '0;
        win_id_d  = '0;
        win_vld_d = 1'b0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (elig[i] && (prio_q[i] > best_p)) begin
                best_p    = prio_q[i];
                win_id_d  = IDW'(i);
                win_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NUM_IRQS; i++) prio_q[i] <= '0;
            act_d_q   <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            type_q    <= '0;
            pol_q     <= '0;
            insvc_q   <= '0;
            thr_q     <= '0;
            sup_q     <= 1'b0;
            win_vld_q <= 1'b0;
            win_id_q  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            act_d_q   <= act;
            pending_q <= pending_d;
            insvc_q   <= insvc_d;
            win_vld_q <= win_vld_d;
            win_id_q  <= win_id_d;
            // Changing POL/TYPE shifts act without a real source edge; mask detection for one cycle.
            sup_q     <= wr_en && (hit_type || hit_pol);
            if (wr_en && hit_enable) enable_q <= wdat_n;
            if (wr_en && hit_type)   type_q   <= wdat_n;
            if (wr_en && hit_pol)    pol_q    <= wdat_n;
            if (wr_en && hit_thr)    thr_q    <= reg_wdata[PRIO_WIDTH-1:0];
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (wr_en && hit_prio[i]) prio_q[i] <= reg_wdata[PRIO_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (hit_status)      reg_rdata[NUM_IRQS-1:0] = pending_q;
        else if (hit_enable) reg_rdata[NUM_IRQS-1:0] = enable_q;
        else if (hit_type)   reg_rdata[NUM_IRQS-1:0] = type_q;
        else if (hit_pol)    reg_rdata[NUM_IRQS-1:0] = pol_q;
        else if (hit_thr)    reg_rdata[PRIO_WIDTH-1:0] = thr_q;
        else if (hit_raw)    reg_rdata[NUM_IRQS-1:0] = act;
        else if (hit_insvc)  reg_rdata[NUM_IRQS-1:0] = insvc_q;
        else if (hit_claim) begin
            reg_rdata[31]      = win_vld_q;
            reg_rdata[IDW-1:0] = win_id_q;
        end else begin
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (hit_prio[i]) reg_rdata[PRIO_WIDTH-1:0] = prio_q[i];
            end
        end
    end

    assign irq_out = win_vld_q;
    assign irq_id  = win_id_q;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_irq_prio_ctrl;
    localparam int N = 16;

    localparam logic [7:0] A_STATUS = 8'h00, A_ENABLE = 8'h04, A_TYPE = 8'h08, A_POL = 8'h0C;
    localparam logic [7:0] A_THR = 8'h10, A_RAW = 8'h14, A_CLAIM = 8'h18, A_INSV = 8'h1C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_in;
    logic          irq_out;
    logic [4:0]    irq_id;
    logic          reg_wr, reg_rd;
    logic [7:0]    reg_addr;
    logic [31:0]   reg_wdata, reg_rdata;

    irq_prio_ctrl #(.NUM_IRQS(N), .PRIO_WIDTH(3), .SYNC_STAGES(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_out(irq_out), .irq_id(irq_id),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    bit   obs_vld = 1'b0;
    bit   stim_done = 1'b0;
    bit   end_checked = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Monitor: a register read (without a concurrent write) or an irq observation presents an output.
    always @(negedge clk) begin
        logic [31:0] got;
        exp_t        e;
        if ((reg_rd && !reg_wr) || obs_vld) begin
            got = obs_vld ? {irq_out, 26'b0, irq_id} : reg_rdata;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%08h with empty scoreboard", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.val) begin
                    bad++;
                    $display("FAIL %s got=%08h exp=%08h", e.name, got, e.val);
                end
            end
        end
        if (stim_done && !end_checked) begin
            end_checked = 1'b1;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL scoreboard_drain got=%0d leftover exp=0", exp_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name; e.val = exp;
        exp_q.push_back(e);
        reg_rd = 1'b1; reg_addr = a;
        tick();
        reg_rd = 1'b0;
    endtask

    task automatic wrrd(input logic [7:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic obs(input logic o, input logic [4:0] id, input string name);
        exp_t e;
        e.name = name; e.val = {o, 26'b0, id};
        exp_q.push_back(e);
        obs_vld = 1'b1;
        tick();
        obs_vld = 1'b0;
    endtask

    task automatic do_reset();
        irq_in = '0;
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        obs(1'b0, 5'd0, "reset_irq");
        rd(A_STATUS, 32'h0, "reset_status");
        rd(A_ENABLE, 32'h0, "reset_enable");
        rd(8'h40, 32'h0, "reset_prio0");

        // Level source 3: latency, claim, complete with input still high.
        wr(A_ENABLE, 32'h8);
        wr(8'h4C, 32'd2);
        irq_in[3] = 1'b1;
        repeat (3) tick();
        obs(1'b0, 5'd0, "latency_early");
        obs(1'b1, 5'd3, "latency_hit");
        rd(A_CLAIM, 32'h8000_0003, "claim_lvl3");
        obs(1'b0, 5'd0, "post_claim_low");
        rd(A_INSV, 32'h8, "insvc_3");
        wr(A_CLAIM, 32'd3);
        tick();
        obs(1'b1, 5'd3, "lvl_repend");

        // Edge source 5, active-low.
        do_reset();
        wr(A_TYPE, 32'h20);
        wr(A_POL, 32'h20);
        rd(A_RAW, 32'h20, "raw_pol");
        tick();
        rd(A_STATUS, 32'h0, "pol_no_spurious");
        irq_in[5] = 1'b1;
        repeat (4) tick();
        irq_in[5] = 1'b0;
        repeat (4) tick();
        rd(A_STATUS, 32'h20, "edge_set");
        wr(A_STATUS, 32'h20);
        rd(A_STATUS, 32'h0, "edge_w1c");
        irq_in[5] = 1'b1;
        repeat (4) tick();
        irq_in[5] = 1'b0;
        repeat (2) tick();
        wr(A_STATUS, 32'h20);
        rd(A_STATUS, 32'h20, "set_beats_w1c");

        // Priority order, then tie-break on lowest id.
        do_reset();
        irq_in = N'(32'h84);
        wr(8'h48, 32'd4);
        wr(8'h5C, 32'd6);
        wr(A_ENABLE, 32'h84);
        repeat (5) tick();
        rd(A_CLAIM, 32'h8000_0007, "claim_hi_prio");
        rd(A_CLAIM, 32'h8000_0002, "claim_next");
        rd(A_INSV, 32'h84, "insvc_2_7");
        do_reset();
        irq_in = N'(32'h204);
        wr(8'h48, 32'd4);
        wr(8'h64, 32'd4);
        wr(A_ENABLE, 32'h204);
        repeat (5) tick();
        obs(1'b1, 5'd2, "tie_irq");
        rd(A_CLAIM, 32'h8000_0002, "tie_claim");

        // Threshold boundary and field truncation.
        do_reset();
        irq_in = N'(32'h10);
        wr(8'h50, 32'h0D);
        rd(8'h50, 32'd5, "prio_trunc");
        wr(A_THR, 32'd5);
        wr(A_ENABLE, 32'h10);
        repeat (5) tick();
        obs(1'b0, 5'd0, "thr_equal_blocks");
        wr(A_THR, 32'h0C);
        rd(A_THR, 32'd4, "thr_trunc");
        obs(1'b1, 5'd4, "thr_below_fires");

        // Empty claim, out-of-range complete, write+read collision.
        do_reset();
        rd(A_CLAIM, 32'h0, "claim_none");
        rd(A_INSV, 32'h0, "claim_none_insvc");
        irq_in = N'(32'h8000);
        wr(8'h7C, 32'd1);
        wr(A_ENABLE, 32'h8000);
        repeat (5) tick();
        rd(A_CLAIM, 32'h8000_000F, "claim_15");
        rd(A_CLAIM, 32'h0, "claim_none_busy");
        rd(A_INSV, 32'h8000, "insvc_15");
        wr(A_CLAIM, 32'd31);
        rd(A_INSV, 32'h8000, "complete_oob");
        wr(A_CLAIM, 32'd15);
        repeat (3) tick();
        obs(1'b1, 5'd15, "repend_15");
        wrrd(A_CLAIM, 32'd15);
        rd(A_INSV, 32'h0, "wr_rd_no_claim");

        // Reset while source 1 is in service and pending.
        do_reset();
        wr(A_TYPE, 32'h2);
        wr(8'h44, 32'd3);
        wr(A_ENABLE, 32'h2);
        irq_in[1] = 1'b1;
        repeat (5) tick();
        rd(A_CLAIM, 32'h8000_0001, "claim_1");
        irq_in[1] = 1'b0;
        repeat (4) tick();
        irq_in[1] = 1'b1;
        repeat (4) tick();
        rd(A_STATUS, 32'h2, "pre_rst_pending");
        rd(A_INSV, 32'h2, "pre_rst_insvc");
        rst_n = 1'b0;
        tick();
        obs(1'b0, 5'd0, "rst_irq_low");
        rd(A_STATUS, 32'h0, "rst_status");
        rd(A_INSV, 32'h0, "rst_insvc");
        rd(A_ENABLE, 32'h0, "rst_enable");
        rd(8'h44, 32'h0, "rst_prio1");
        rst_n = 1'b1;
        repeat (3) tick();
        wr(A_TYPE, 32'h2);
        wr(A_STATUS, 32'h2);
        wr(8'h44, 32'd3);
        wr(A_ENABLE, 32'h2);
        repeat (5) tick();
        obs(1'b0, 5'd0, "no_holdover");
        irq_in[1] = 1'b0;
        repeat (4) tick();
        irq_in[1] = 1'b1;
        repeat (5) tick();
        obs(1'b1, 5'd1, "new_edge_fires");

        stim_done = 1'b1;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
